// File: rtl/vga_sync_module.sv
// VGA pixel-timing generator: free-running h/v counters with registered sync,
// coordinate and active-area decodes, all lagging the counters by one clock.
module vga_sync_module #(
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic       VGA_CLK,
  input  logic       RST_N,
  output logic       VGA_HSYNC,
  output logic       VGA_VSYNC,
  output logic [9:0] X,
  output logic [9:0] Y,
  output logic       valid,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int unsigned H_START = H_SYNC + H_BACK;
  localparam int unsigned H_END   = H_START + H_ACTIVE;
  localparam int unsigned V_START = V_SYNC + V_BACK;
  localparam int unsigned V_END   = V_START + V_ACTIVE;

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_last;
  logic       v_last;
  logic       h_sync;
  logic       v_sync;
  logic       h_act;
  logic       v_act;
  logic       origin;

  // Compares are done at 11 bits so a window ending exactly at 1024 still decodes.
  always_comb begin
    h_last = ({1'b0, h_cnt} == 11'(H_TOTAL - 1));
    v_last = ({1'b0, v_cnt} == 11'(V_TOTAL - 1));
    h_sync = ({1'b0, h_cnt} < 11'(H_SYNC));
    v_sync = ({1'b0, v_cnt} < 11'(V_SYNC));
    h_act  = ({1'b0, h_cnt} >= 11'(H_START)) && ({1'b0, h_cnt} < 11'(H_END));
    v_act  = ({1'b0, v_cnt} >= 11'(V_START)) && ({1'b0, v_cnt} < 11'(V_END));
    origin = (h_cnt == '0) && (v_cnt == '0);
  end

  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      VGA_HSYNC   <= ~SYNC_POL;
      VGA_VSYNC   <= ~SYNC_POL;
      X           <= '0;
      Y           <= '0;
      valid       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      VGA_HSYNC   <= h_sync ? SYNC_POL : ~SYNC_POL;
      VGA_VSYNC   <= v_sync ? SYNC_POL : ~SYNC_POL;
      valid       <= h_act && v_act;
      X           <= (h_act && v_act) ? h_cnt - 10'(H_START) : '0;
      Y           <= (h_act && v_act) ? v_cnt - 10'(V_START) : '0;
      frame_start <= origin;
    end
  end

endmodule

// File: tb/tb_vga_sync_module.sv
// Bench for vga_sync_module: three timing configurations checked every clock
// against a flat pixel-position model, plus literal timing pins.
module tb_vga_sync_module;

  typedef struct {
    int hs, hb, ha, hf, vs, vb, va, vf;
    bit pol;
  } timing_t;

  typedef struct {
    bit hsync, vsync, valid, fs;
    int x, y;
  } outs_t;

  localparam timing_t T0 = '{96, 48, 640, 16, 2, 33, 480, 10, 1'b0};
  localparam timing_t T1 = '{8, 2, 4, 2, 3, 1, 2, 1, 1'b1};
  localparam timing_t T2 = '{10, 6, 40, 4, 2, 3, 20, 2, 1'b0};

  logic clk;
  logic rst_n;
  longint edges;
  int errors;
  int checks;
  int vcount1;
  int vcount2;

  logic       d0_hs, d0_vs, d0_valid, d0_fs;
  logic [9:0] d0_x, d0_y;
  logic       d1_hs, d1_vs, d1_valid, d1_fs;
  logic [9:0] d1_x, d1_y;
  logic       d2_hs, d2_vs, d2_valid, d2_fs;
  logic [9:0] d2_x, d2_y;

  vga_sync_module dut0 (
    .VGA_CLK(clk), .RST_N(rst_n), .VGA_HSYNC(d0_hs), .VGA_VSYNC(d0_vs),
    .X(d0_x), .Y(d0_y), .valid(d0_valid), .frame_start(d0_fs)
  );

  vga_sync_module #(
    .H_SYNC(8), .H_BACK(2), .H_ACTIVE(4), .H_FRONT(2),
    .V_SYNC(3), .V_BACK(1), .V_ACTIVE(2), .V_FRONT(1),
    .SYNC_POL(1'b1)
  ) dut1 (
    .VGA_CLK(clk), .RST_N(rst_n), .VGA_HSYNC(d1_hs), .VGA_VSYNC(d1_vs),
    .X(d1_x), .Y(d1_y), .valid(d1_valid), .frame_start(d1_fs)
  );

  vga_sync_module #(
    .H_SYNC(10), .H_BACK(6), .H_ACTIVE(40), .H_FRONT(4),
    .V_SYNC(2), .V_BACK(3), .V_ACTIVE(20), .V_FRONT(2),
    .SYNC_POL(1'b0)
  ) dut2 (
    .VGA_CLK(clk), .RST_N(rst_n), .VGA_HSYNC(d2_hs), .VGA_VSYNC(d2_vs),
    .X(d2_x), .Y(d2_y), .valid(d2_valid), .frame_start(d2_fs)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edges seen since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 64'd1;
  end

  // Output n of a free-running raster describes flat pixel position n-1 of the frame.
  function automatic outs_t model(timing_t t, bit in_reset, longint n);
    outs_t o;
    longint ht, vt, p, h, v;
    o.hsync = ~t.pol;
    o.vsync = ~t.pol;
    o.valid = 1'b0;
    o.fs    = 1'b0;
    o.x     = 0;
    o.y     = 0;
    if (!in_reset && n > 0) begin
      ht = t.hs + t.hb + t.ha + t.hf;
      vt = t.vs + t.vb + t.va + t.vf;
      p  = (n - 1) % (ht * vt);
      h  = p % ht;
      v  = p / ht;
      o.hsync = (h < t.hs) ? t.pol : ~t.pol;
      o.vsync = (v < t.vs) ? t.pol : ~t.pol;
      o.valid = (h >= t.hs + t.hb) && (h < t.hs + t.hb + t.ha) &&
                (v >= t.vs + t.vb) && (v < t.vs + t.vb + t.va);
      o.fs    = (p == 0);
      if (o.valid) begin
        o.x = int'(h) - (t.hs + t.hb);
        o.y = int'(v) - (t.vs + t.vb);
      end
    end
    return o;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at t=%0t edge=%0d: got %0d, expected %0d", name, $time, edges, act, exp);
    end
  endtask

  task automatic check_dut(input string tag, input timing_t t, input logic hs, input logic vs,
                           input logic [9:0] x, input logic [9:0] y, input logic vld,
                           input logic fs);
    outs_t e;
    e = model(t, !rst_n, edges);
    chk({tag, "_hsync"}, hs, e.hsync);
    chk({tag, "_vsync"}, vs, e.vsync);
    chk({tag, "_valid"}, vld, e.valid);
    chk({tag, "_x"}, x, e.x);
    chk({tag, "_y"}, y, e.y);
    chk({tag, "_frame_start"}, fs, e.fs);
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    vcount1 = 0;
    vcount2 = 0;
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      if (clk && !rst_n) begin
        chk("async_clear_hsync", d0_hs, 1);
        chk("async_clear_vsync", d0_vs, 1);
        chk("async_clear_valid", d0_valid, 0);
        chk("async_clear_x", d0_x, 0);
        chk("async_clear_y", d0_y, 0);
        chk("async_clear_fs", d0_fs, 0);
        chk("async_clear_hsync_pol1", d1_hs, 0);
      end
      check_dut("d0", T0, d0_hs, d0_vs, d0_x, d0_y, d0_valid, d0_fs);
      check_dut("d1", T1, d1_hs, d1_vs, d1_x, d1_y, d1_valid, d1_fs);
      check_dut("d2", T2, d2_hs, d2_vs, d2_x, d2_y, d2_valid, d2_fs);
      if (!clk && rst_n) begin
        case (edges)
          1: begin
            chk("pin_d0_first_hsync", d0_hs, 0);
            chk("pin_d0_first_vsync", d0_vs, 0);
            chk("pin_d0_first_fs", d0_fs, 1);
            chk("pin_d1_first_hsync", d1_hs, 1);
            chk("pin_d1_first_fs", d1_fs, 1);
          end
          8:     chk("pin_d1_hsync_last_asserted", d1_hs, 1);
          9:     chk("pin_d1_hsync_deasserted", d1_hs, 0);
          75: begin
            chk("pin_d1_first_valid", d1_valid, 1);
            chk("pin_d1_first_x", d1_x, 0);
            chk("pin_d1_first_y", d1_y, 0);
          end
          96:    chk("pin_d0_hsync_last_asserted", d0_hs, 0);
          97:    chk("pin_d0_hsync_deasserted", d0_hs, 1);
          113:   chk("pin_d1_second_frame_start", d1_fs, 1);
          801:   chk("pin_d0_second_line_hsync", d0_hs, 0);
          1600:  chk("pin_d0_vsync_last_asserted", d0_vs, 0);
          1601:  chk("pin_d0_vsync_deasserted", d0_vs, 1);
          1621:  chk("pin_d2_second_frame_start", d2_fs, 1);
          28144: chk("pin_d0_before_first_valid", d0_valid, 0);
          28145: begin
            chk("pin_d0_first_valid", d0_valid, 1);
            chk("pin_d0_first_x", d0_x, 0);
            chk("pin_d0_first_y", d0_y, 0);
          end
          28784: begin
            chk("pin_d0_last_valid_in_line", d0_valid, 1);
            chk("pin_d0_x639", d0_x, 639);
          end
          28785: begin
            chk("pin_d0_front_porch_valid", d0_valid, 0);
            chk("pin_d0_front_porch_x", d0_x, 0);
          end
          default: ;
        endcase
        if (edges == 1) begin
          vcount1 = 0;
          vcount2 = 0;
        end
        if (d1_valid && edges <= 112) vcount1++;
        if (d2_valid && edges <= 1620) vcount2++;
        if (edges == 112)  chk("pin_d1_valid_per_frame", vcount1, 8);
        if (edges == 1620) chk("pin_d2_valid_per_frame", vcount2, 800);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (30000) @(posedge clk);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #2 rst_n = 1'b0;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat ($urandom_range(100, 2500)) @(posedge clk);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2000) @(posedge clk);
    @(negedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
